// File: rtl/sha256_pkg.sv
// Shared SHA-256 readout definitions: digest geometry, reader state
// encoding and the byte-reversal helper used for little-endian consumers.
package sha256_pkg;

  localparam int unsigned DIGEST_WORDS = 8;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned ADDR_W       = 6;

  // Reader FSM encoding, kept as plain 2-bit constants for compatibility
  // with the legacy netlists that probe the state register.
  typedef logic [1:0] rdr_state_t;

  localparam rdr_state_t ST_IDLE    = 2'd0;
  localparam rdr_state_t ST_CAPTURE = 2'd1;
  localparam rdr_state_t ST_SEND    = 2'd2;
  localparam rdr_state_t ST_DONE    = 2'd3;

  // Reverse the byte order of one 32-bit digest word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_digest_reader_if.sv
// Valid/ready stream carrying digest words out of the reader.
// master: the reader (drives data, valid, last); slave: the KDF consumer.
interface sha256_digest_reader_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/sha256_digest_reader.sv
// SHA-256 digest reader: after the address counter raises eoc, walks the
// counter through digest words 0..NUM_WORDS-1 with single-cycle rd strobes,
// registers each word from the core and presents it on a valid/ready stream.
// Optional build macro: DIGEST_BYTESWAP_EN -- captured words are
// byte-reversed for little-endian consumers (requires WORD_W == 32).
module sha256_digest_reader #(
  parameter int unsigned WORD_W    = sha256_pkg::WORD_W,
  parameter int unsigned NUM_WORDS = sha256_pkg::DIGEST_WORDS,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          eoc,
  input  logic [sha256_pkg::ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0]             digest_word,
  output logic                          rd,
  sha256_digest_reader_if.master        stream,
  output logic                          done,
  output logic                          idx_err
);

  import sha256_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  rdr_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              dout_last_q;
  logic              done_q;
  logic              idx_err_q;
  logic [WORD_W-1:0] cap_word;
  logic              at_last;
  logic              unused_addr_hi;

  // Only the low index bits of the counter address are compared.
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

  assign at_last = (idx == LAST_IDX);

`ifdef DIGEST_BYTESWAP_EN
  assign cap_word = byte_swap32(digest_word);
`else
  assign cap_word = digest_word;
`endif

  // Advance strobe: only when a non-final word is accepted while eoc still
  // holds, so the counter steps on the same edge the FSM returns to CAPTURE.
  always_comb begin
    rd = 1'b0;
    if (state == ST_SEND && eoc && stream.dout_ready && !at_last) begin
      rd = 1'b1;
    end
  end

  // Readout FSM, capture register and sticky index check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      idx_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eoc) begin
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (!eoc) begin
            // Counter restarted early: drop the readout without a done pulse.
            state        <= ST_IDLE;
            idx          <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
          end else begin
            dout_q       <= cap_word;
            dout_valid_q <= 1'b1;
            dout_last_q  <= at_last;
            if (addr[IDX_W-1:0] != idx) begin
              idx_err_q <= 1'b1;
            end
            state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!eoc) begin
            state        <= ST_IDLE;
            idx          <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
          end else if (stream.dout_ready) begin
            dout_valid_q <= 1'b0;
            if (at_last) begin
              // Counter is left parked on the final word; no rd here.
              dout_last_q <= 1'b0;
              done_q      <= 1'b1;
              idx         <= '0;
              state       <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_CAPTURE;
            end
          end
        end

        ST_DONE: begin
          // Hold until the counter is restarted so a stale digest is never
          // read twice.
          if (!eoc) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign stream.dout       = dout_q;
  assign stream.dout_valid = dout_valid_q;
  assign stream.dout_last  = dout_last_q;
  assign done              = done_q;
  assign idx_err           = idx_err_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader with a small address-counter
// model and a digest-word table standing in for the hash core.
module tb_sha256_digest_reader;

  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eoc;
  logic [5:0]  addr;
  logic [31:0] digest_word;
  logic        rd;
  logic        done;
  logic        idx_err;

  logic        cnt_load;
  logic [5:0]  cnt_val;
  logic [31:0] dig [8];

  int n_checks = 0;
  int n_errors = 0;
  int words    = 0;
  int rd_n     = 0;
  int done_n   = 0;
  int exp_k    = 0;
  bit chk_data = 1'b1;

`ifdef DIGEST_BYTESWAP_EN
  localparam logic [31:0] SWAP_EXP = 32'h44332211;
`else
  localparam logic [31:0] SWAP_EXP = 32'h11223344;
`endif

  sha256_digest_reader_if #(.WORD_W(32)) stream ();

  sha256_digest_reader #(
    .WORD_W   (32),
    .NUM_WORDS(8),
    .IDX_W    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eoc        (eoc),
    .addr       (addr),
    .digest_word(digest_word),
    .rd         (rd),
    .stream     (stream.master),
    .done       (done),
    .idx_err    (idx_err)
  );

  always #5 clk = ~clk;

  assign digest_word = dig[addr[2:0]];

  // Address counter model: steps on rd, loadable for restart/misalignment.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr <= 6'd0;
    else if (cnt_load) addr <= cnt_val;
    else if (rd) addr <= addr + 6'd1;
  end

  function automatic logic [31:0] expect_word(input logic [31:0] w);
`ifdef DIGEST_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    if (!rst_n || !eoc) exp_k = 0;
    if (stream.dout_valid && stream.dout_ready) begin
      if (chk_data) check("word", stream.dout, expect_word(dig[exp_k % 8]));
      check("last", 32'(stream.dout_last), 32'(exp_k == 7));
      exp_k++;
      words++;
    end
    if (rd) rd_n++;
    if (done) done_n++;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int i = 0; i < budget && words < target; i++) step();
    check("words_reached", 32'(words >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_n;
    for (int i = 0; i < budget && done_n == start; i++) step();
    check("done_seen", 32'(done_n - start), 32'd1);
  endtask

  task automatic end_run();
    eoc = 1'b0;
    step();
    step();
    cnt_load = 1'b1;
    cnt_val  = 6'd0;
    step();
    cnt_load = 1'b0;
  endtask

  initial begin
    int bw, br, bd;
    dig[0] = 32'h6a09e667; dig[1] = 32'hbb67ae85;
    dig[2] = 32'h3c6ef372; dig[3] = 32'ha54ff53a;
    dig[4] = 32'h510e527f; dig[5] = 32'h9b05688c;
    dig[6] = 32'h1f83d9ab; dig[7] = 32'h5be0cd19;
    rst_n = 1'b0;
    eoc = 1'b0;
    cnt_load = 1'b0;
    cnt_val = 6'd0;
    stream.dout_ready = 1'b1;

    #2;
    check("rst_dout", stream.dout, 32'h0);
    check("rst_valid", 32'(stream.dout_valid), 32'd0);
    check("rst_last", 32'(stream.dout_last), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx_err", 32'(idx_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // 1: full readout with ready held high
    bw = words; br = rd_n; bd = done_n;
    eoc = 1'b1;
    step();
    check("lat1_valid", 32'(stream.dout_valid), 32'd0);
    step();
    check("lat2_valid", 32'(stream.dout_valid), 32'd1);
    check("lat2_dout", stream.dout, expect_word(32'h6a09e667));
    wait_done(40);
    step();
    step();
    check("t1_words", 32'(words - bw), 32'd8);
    check("t1_rd", 32'(rd_n - br), 32'd7);
    check("t1_done_once", 32'(done_n - bd), 32'd1);
    check("t1_idx_err", 32'(idx_err), 32'd0);
    end_run();

    // 2: backpressure on word 3
    bw = words; br = rd_n;
    eoc = 1'b1;
    wait_words(bw + 3, 40);
    stream.dout_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_dout", stream.dout, expect_word(32'ha54ff53a));
      check("t2_hold_valid", 32'(stream.dout_valid), 32'd1);
      check("t2_hold_rd", 32'(rd), 32'd0);
    end
    check("t2_rd_during_hold", 32'(rd_n - br), 32'd3);
    stream.dout_ready = 1'b1;
    wait_done(40);
    check("t2_words", 32'(words - bw), 32'd8);
    check("t2_rd", 32'(rd_n - br), 32'd7);
    end_run();

    // 3: early restart while sending word 2
    bd = done_n;
    eoc = 1'b1;
    wait_words(words + 2, 40);
    stream.dout_ready = 1'b0;
    step();
    check("t3_send_valid", 32'(stream.dout_valid), 32'd1);
    br = rd_n;
    eoc = 1'b0;
    step();
    check("t3_abort_valid", 32'(stream.dout_valid), 32'd0);
    step();
    step();
    check("t3_idle_valid", 32'(stream.dout_valid), 32'd0);
    check("t3_no_done", 32'(done_n - bd), 32'd0);
    check("t3_no_rd", 32'(rd_n - br), 32'd0);
    cnt_load = 1'b1;
    cnt_val = 6'd0;
    step();
    cnt_load = 1'b0;
    stream.dout_ready = 1'b1;
    bw = words;
    eoc = 1'b1;
    step();
    step();
    check("t3_restart_valid", 32'(stream.dout_valid), 32'd1);
    check("t3_restart_dout", stream.dout, expect_word(32'h6a09e667));
    wait_done(40);
    check("t3_words", 32'(words - bw), 32'd8);
    end_run();

    // 4: counter misaligned by one word
    cnt_load = 1'b1;
    cnt_val = 6'd1;
    step();
    cnt_load = 1'b0;
    chk_data = 1'b0;
    eoc = 1'b1;
    wait_done(40);
    check("t4_idx_err", 32'(idx_err), 32'd1);
    end_run();
    step();
    check("t4_idx_err_sticky", 32'(idx_err), 32'd1);
    chk_data = 1'b1;

    // 5: asynchronous reset while word 5 is presented
    eoc = 1'b1;
    wait_words(words + 5, 40);
    step();
    check("t5_pre_valid", 32'(stream.dout_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", stream.dout, 32'h0);
    check("t5_rst_valid", 32'(stream.dout_valid), 32'd0);
    check("t5_rst_last", 32'(stream.dout_last), 32'd0);
    check("t5_rst_rd", 32'(rd), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_idx_err", 32'(idx_err), 32'd0);
    eoc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bw = words;
    eoc = 1'b1;
    step();
    check("t5_lat1_valid", 32'(stream.dout_valid), 32'd0);
    step();
    check("t5_first_valid", 32'(stream.dout_valid), 32'd1);
    check("t5_first_dout", stream.dout, expect_word(32'h6a09e667));
    wait_done(40);
    check("t5_words", 32'(words - bw), 32'd8);
    check("t5_idx_err", 32'(idx_err), 32'd0);
    end_run();

    // 6: byte order of the captured word
    dig[0] = 32'h11223344;
    eoc = 1'b1;
    step();
    step();
    check("t6_order", stream.dout, SWAP_EXP);
    wait_done(40);
    end_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
